// File: rtl/nand_wen_nclk_ctrl_if.sv
// Request/response and WE#/NCLK select bundle for one NAND bus sequencer.
interface nand_wen_nclk_ctrl_if #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PULSE_W = 4
);
    logic               i_req_valid;
    logic               o_req_ready;
    logic [PULSE_W-1:0] i_pulse_cnt;
    logic [CNT_W-1:0]   i_t_low;
    logic [CNT_W-1:0]   i_t_high;
    logic               i_mode_sync;
    logic               o_done;
    logic               o_sync_active;
    logic               v_ctrl_wen;
    logic               v_ctrl_wen_sel;

    modport master (
        output i_req_valid, i_pulse_cnt, i_t_low, i_t_high, i_mode_sync,
        input  o_req_ready, o_done, o_sync_active, v_ctrl_wen, v_ctrl_wen_sel
    );

    modport slave (
        input  i_req_valid, i_pulse_cnt, i_t_low, i_t_high, i_mode_sync,
        output o_req_ready, o_done, o_sync_active, v_ctrl_wen, v_ctrl_wen_sel
    );
endinterface

// File: rtl/nand_wen_nclk_ctrl.sv
// WE# pulse-burst / NCLK-select sequencer feeding one bus's ODDR stage.
// Sync (NV-DDR clock) mode is built only when NAND_WEN_SYNC_EN is defined.
module nand_wen_nclk_ctrl #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned PULSE_W = 4
) (
    input  logic                 v_clk0,
    input  logic                 v_rst0,
    nand_wen_nclk_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
`ifdef NAND_WEN_SYNC_EN
        ,
        ST_SYNC_ENTER,
        ST_SYNC_RUN,
        ST_SYNC_EXIT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   phase_q, phase_d;
    logic [CNT_W-1:0]   t_low_q, t_low_d;
    logic [CNT_W-1:0]   t_high_q, t_high_d;
    logic [PULSE_W-1:0] remain_q, remain_d;
    logic               wen_q, wen_d;
    logic               sel_q, sel_d;
    logic               done_q, done_d;
    logic               sync_q, sync_d;
    logic               mode_sync_c;
    logic               ready_c;

    // A programmed phase length of 0 behaves as 1 cycle.
    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

`ifdef NAND_WEN_SYNC_EN
    assign mode_sync_c = bus.i_mode_sync;
`else
    assign mode_sync_c = 1'b0;
`endif

    assign ready_c = (state_q == ST_IDLE) && !mode_sync_c;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        t_low_d  = t_low_q;
        t_high_d = t_high_q;
        remain_d = remain_q;
        wen_d    = 1'b1;
        sel_d    = 1'b1;
        done_d   = 1'b0;
        sync_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
`ifdef NAND_WEN_SYNC_EN
                if (bus.i_mode_sync) begin
                    state_d = ST_SYNC_ENTER;
                    phase_d = eff_len(bus.i_t_high);
                end
`endif
                if (ready_c && bus.i_req_valid) begin
                    t_low_d  = eff_len(bus.i_t_low);
                    t_high_d = eff_len(bus.i_t_high);
                    if (bus.i_pulse_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_LOW;
                        wen_d    = 1'b0;
                        phase_d  = eff_len(bus.i_t_low);
                        remain_d = bus.i_pulse_cnt;
                    end
                end
            end
            ST_LOW: begin
                wen_d = 1'b0;
                if (phase_q == CNT_W'(1)) begin
                    state_d = ST_HIGH;
                    wen_d   = 1'b1;
                    phase_d = t_high_q;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (phase_q == CNT_W'(1)) begin
                    remain_d = remain_q - PULSE_W'(1);
                    if (remain_q > PULSE_W'(1)) begin
                        state_d = ST_LOW;
                        wen_d   = 1'b0;
                        phase_d = t_low_q;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
`ifdef NAND_WEN_SYNC_EN
            ST_SYNC_ENTER: begin
                if (phase_q == CNT_W'(1)) begin
                    state_d = ST_SYNC_RUN;
                    sel_d   = 1'b0;
                    sync_d  = 1'b1;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
            ST_SYNC_RUN: begin
                sel_d  = 1'b0;
                sync_d = 1'b1;
                if (!bus.i_mode_sync) begin
                    state_d = ST_SYNC_EXIT;
                    sel_d   = 1'b1;
                    sync_d  = 1'b0;
                    phase_d = eff_len(bus.i_t_high);
                end
            end
            ST_SYNC_EXIT: begin
                if (phase_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    phase_d = phase_q - CNT_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset forces WE# high and the select to level mode without waiting for a clock.
    always_ff @(posedge v_clk0 or posedge v_rst0) begin
        if (v_rst0) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            t_low_q  <= '0;
            t_high_q <= '0;
            remain_q <= '0;
            wen_q    <= 1'b1;
            sel_q    <= 1'b1;
            done_q   <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            t_low_q  <= t_low_d;
            t_high_q <= t_high_d;
            remain_q <= remain_d;
            wen_q    <= wen_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            sync_q   <= sync_d;
        end
    end

    assign bus.o_req_ready    = ready_c;
    assign bus.o_done         = done_q;
    assign bus.o_sync_active  = sync_q;
    assign bus.v_ctrl_wen     = wen_q;
    assign bus.v_ctrl_wen_sel = sel_q;

endmodule

// File: doc/nand_wen_nclk_ctrl.md
# nand_wen_nclk_ctrl

Per-bus sequencer that drives the `v_ctrl_wen` / `v_ctrl_wen_sel` pair consumed by the NAND WE#/NCLK ODDR stage.
- Async (SDR) mode: generates timed WE# pulse bursts for command/address/data latching.
- Sync (NV-DDR) mode: releases the select so the ODDR stage emits a free-running NAND clock.
- Each flash bus has one instance; the two outputs connect directly to that bus's `v_ctrl_wen_N` / `v_ctrl_wen_sel_N` inputs.

## Interface
Parameters:
- `CNT_W`, 8: width of the low/high phase cycle counters.
- `PULSE_W`, 4: width of the pulse-count field.

Ports:
- `v_clk0`  in  1  bus controller clock; same clock as the ODDR stage.
- `v_rst0`  in  1  reset, asynchronous, active-high.
- `i_req_valid`  in  1  burst request.
- `o_req_ready`  out  1  burst request accepted when high together with `i_req_valid`.
- `i_pulse_cnt`  in  PULSE_W  number of WE# pulses in the burst (0 legal).
- `i_t_low`  in  CNT_W  cycles WE# held low per pulse; 0 treated as 1.
- `i_t_high`  in  CNT_W  cycles WE# held high after each pulse, and sync entry/exit guard; 0 treated as 1.
- `i_mode_sync`  in  1  level: 1 requests sync (clock) mode.
- `o_done`  out  1  one-cycle pulse when a burst completes.
- `o_sync_active`  out  1  high while the NAND clock is running.
- `v_ctrl_wen`  out  1  WE# level to the ODDR stage.
- `v_ctrl_wen_sel`  out  1  1 = drive `v_ctrl_wen` level; 0 = ODDR toggles (clock).

## Operation
- States: IDLE, LOW, HIGH, SYNC_ENTER, SYNC_RUN, SYNC_EXIT. All outputs except `o_req_ready` are registered.
- `o_req_ready` = (state==IDLE) & ~`i_mode_sync`.
- On accept, `i_pulse_cnt`, `i_t_low`, `i_t_high` are latched. Later input changes do not affect the burst in flight.
- IDLE → LOW on accept with N>0. IDLE → IDLE with `o_done` next cycle when N=0, and no WE# activity.
- LOW: `wen`=0 for L cycles, then → HIGH.
- HIGH: `wen`=1 for H cycles. Then:
  - decrement the remaining count;
  - → LOW if pulses remain;
  - else → IDLE with `o_done`=1 for one cycle.
- `v_ctrl_wen_sel`=1 in every state except SYNC_RUN.
- IDLE with `i_mode_sync`=1 → SYNC_ENTER, latching H from `i_t_high`. Mode takes priority over a simultaneous valid, since ready is 0.
- SYNC_ENTER: `wen`=1 for H cycles → SYNC_RUN.
- SYNC_RUN: `sel`=0, `wen`=1, `o_sync_active`=1. When `i_mode_sync`=0, → SYNC_EXIT, latching H.
- SYNC_EXIT: `sel`=1, `wen`=1 for H cycles → IDLE.
- `i_mode_sync` changes during a burst or guard are ignored until IDLE or SYNC_RUN is reached.
- Reset, at any time including mid-burst or mid-clock: state IDLE. The WE# level goes high immediately (asynchronous) and no `o_done` is issued.

## Timing
- Reset values:
  - `v_ctrl_wen`=1
  - `v_ctrl_wen_sel`=1
  - `o_done`=0
  - `o_sync_active`=0
  - `o_req_ready`=~`i_mode_sync`
- Accept at edge T. With L, H the effective values (≥1):
  - `wen`=0 in cycles T+1..T+L;
  - `wen`=1 in T+L+1..T+L+H;
  - the pattern repeats N times;
  - `o_done`=1 in cycle T+N(L+H)+1, and `o_req_ready` is high in the same cycle, allowing back-to-back bursts with no gap.
- N=0: `o_done` at T+1.
- Sync entry: `i_mode_sync` rises while IDLE at edge S → `sel`=0 from cycle S+H+1.
- Sync exit: fall seen at edge E → `sel`=1 at E+1, `o_sync_active`=0 at E+1, IDLE (ready) at E+H+1.
- Counter width: the L and H counters are CNT_W wide. The maximum phase is 2^CNT_W−1 cycles, with no wrap.

## Configuration
- `NAND_WEN_SYNC_EN` defined:
  - sync states are present;
  - `i_mode_sync` is honoured as described above.
- Not defined:
  - SYNC_* states are removed;
  - `i_mode_sync` is ignored, so ready depends only on IDLE;
  - `v_ctrl_wen_sel` is tied to 1;
  - `o_sync_active` is tied to 0.

## Test plan
- Reset released, idle → `wen`=1, `sel`=1, `o_req_ready`=1, `o_done`=0.
- Burst N=3, L=2, H=3, accepted at T → `wen` low at T+1..2, T+6..7, T+11..12; `o_done` at T+16 only.
- N=0 → `o_done` at T+1, `wen` never low. Then L=0, H=0, N=1 → 1-cycle low, 1-cycle high, `o_done` at T+3.
- `i_mode_sync` 0→1 in IDLE with H=4 at edge S → `sel`=0 from S+5, `o_sync_active`=1, `o_req_ready`=0. Drop it → `sel`=1 next cycle, ready again 4 cycles later.
- `v_rst0` pulse during LOW of a burst and again during SYNC_RUN → `wen`=1 and `sel`=1 asynchronously, no `o_done`, IDLE after release.
- Build without `NAND_WEN_SYNC_EN`, toggle `i_mode_sync` → `sel` stays 1; bursts are unaffected.
